// File: rtl/lb_baud_pkg.sv
// lb_baud_pkg: widths and oversample-ratio constants shared by the baud tick
// generator and the UART RX/TX blocks.
package lb_baud_pkg;

    localparam int unsigned LB_PRESCALE_W = 20;
    localparam int unsigned LB_OVS_W      = 5;
    localparam int unsigned LB_FRAC_W     = 8;
    localparam int unsigned LB_OVS_16X    = 15;
    localparam int unsigned LB_OVS_8X     = 7;

    typedef logic [LB_PRESCALE_W-1:0] lb_prescale_t;
    typedef logic [LB_OVS_W-1:0]      lb_ovs_t;
    typedef logic [LB_FRAC_W-1:0]     lb_frac_t;

    // Common register-file encodings of the oversample ratio (ratio-1).
    typedef enum logic [LB_OVS_W-1:0] {
        LB_RATIO_8X  = LB_OVS_W'(LB_OVS_8X),
        LB_RATIO_16X = LB_OVS_W'(LB_OVS_16X)
    } lb_ovs_ratio_e;

endpackage

// File: rtl/lb_prescale_div.sv
// lb_prescale_div: loadable compare-and-wrap divider. The period is pre_reg+1 clk,
// or pre_reg+2 clk while i_extend is high; o_wrap marks the edge that ends a period.
module lb_prescale_div
    import lb_baud_pkg::*;
#(
    parameter int unsigned           PRESCALE_W   = LB_PRESCALE_W,
    parameter logic [PRESCALE_W-1:0] DEF_PRESCALE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_en,
    input  logic                  i_extend,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_wrap,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_pre_reg;
    // One spare bit so an extended period at maximum prescale still reaches its compare value.
    logic [PRESCALE_W:0]   r_pre_cnt;
    logic                  r_tick;
    logic [PRESCALE_W:0]   w_limit;
    logic                  w_match;

    assign w_limit = {1'b0, r_pre_reg} + {{PRESCALE_W{1'b0}}, i_extend};
    assign w_match = (r_pre_cnt == w_limit);
    assign o_wrap  = i_en & ~i_load & w_match;
    assign o_tick  = r_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_reg <= DEF_PRESCALE;
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (i_load) begin
            r_pre_reg <= i_prescale;
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (i_en) begin
            if (w_match) begin
                r_pre_cnt <= '0;
                r_tick    <= 1'b1;
            end else begin
                r_pre_cnt <= r_pre_cnt + (PRESCALE_W+1)'(1);
                r_tick    <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/lb_baud_tick_gen.sv
// lb_baud_tick_gen: oversample tick, mid-bit and end-of-baud pulse generator.
// Optional fractional divisor enabled by macro LB_BAUD_FRAC_EN.
module lb_baud_tick_gen
    import lb_baud_pkg::*;
#(
    parameter int unsigned           PRESCALE_W   = LB_PRESCALE_W,
    parameter int unsigned           OVS_W        = LB_OVS_W,
    parameter logic [PRESCALE_W-1:0] DEF_PRESCALE = '0,
    parameter logic [OVS_W-1:0]      DEF_OVS      = OVS_W'(LB_OVS_16X)
`ifdef LB_BAUD_FRAC_EN
    ,
    parameter int unsigned           FRAC_W       = LB_FRAC_W
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [OVS_W-1:0]      ovs,
`ifdef LB_BAUD_FRAC_EN
    input  logic [FRAC_W-1:0]     frac,
`endif
    input  logic                  cs,
    input  logic                  load,
    output logic                  tick,
    output logic                  mid_sample,
    output logic                  baud_done,
    output logic [OVS_W-1:0]      ovs_cnt
);

    logic             w_wrap;
    logic             w_extend;
    logic [OVS_W-1:0] r_ovs_reg;
    logic [OVS_W-1:0] r_ovs_cnt;
    logic             r_mid;
    logic             r_done;

    lb_prescale_div #(
        .PRESCALE_W   (PRESCALE_W),
        .DEF_PRESCALE (DEF_PRESCALE)
    ) u_prescale_div (
        .clk        (clk),
        .reset      (reset),
        .i_load     (load),
        .i_en       (cs),
        .i_extend   (w_extend),
        .i_prescale (prescale),
        .o_wrap     (w_wrap),
        .o_tick     (tick)
    );

    // Oversample index within the baud period; decodes use the pre-increment count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovs_reg <= DEF_OVS;
            r_ovs_cnt <= '0;
            r_mid     <= 1'b0;
            r_done    <= 1'b0;
        end else if (load) begin
            r_ovs_reg <= ovs;
            r_ovs_cnt <= '0;
            r_mid     <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_wrap) begin
            r_mid <= (r_ovs_cnt == (r_ovs_reg >> 1));
            if (r_ovs_cnt == r_ovs_reg) begin
                r_ovs_cnt <= '0;
                r_done    <= 1'b1;
            end else begin
                r_ovs_cnt <= r_ovs_cnt + OVS_W'(1);
                r_done    <= 1'b0;
            end
        end else begin
            r_mid  <= 1'b0;
            r_done <= 1'b0;
        end
    end

    assign mid_sample = r_mid;
    assign baud_done  = r_done;
    assign ovs_cnt    = r_ovs_cnt;

`ifdef LB_BAUD_FRAC_EN
    logic [FRAC_W-1:0] r_frac_reg;
    logic [FRAC_W-1:0] r_acc;
    logic              r_extend;
    logic [FRAC_W:0]   w_acc_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac_reg};

    // A carry out of the accumulator stretches the following oversample period by one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frac_reg <= '0;
            r_acc      <= '0;
            r_extend   <= 1'b0;
        end else if (load) begin
            r_frac_reg <= frac;
            r_acc      <= '0;
            r_extend   <= 1'b0;
        end else if (w_wrap) begin
            r_acc      <= w_acc_sum[FRAC_W-1:0];
            r_extend   <= w_acc_sum[FRAC_W];
        end
    end

    assign w_extend = r_extend;
`else
    assign w_extend = 1'b0;
`endif

endmodule

// File: tb/tb_lb_baud_tick_gen.sv
// tb_lb_baud_tick_gen: directed vector table plus hand-written multi-cycle sequences
// for lb_baud_tick_gen (default parameters).
module tb_lb_baud_tick_gen;
    import lb_baud_pkg::*;

    localparam int PW = LB_PRESCALE_W;
    localparam int OW = LB_OVS_W;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] prescale;
    logic [OW-1:0] ovs;
`ifdef LB_BAUD_FRAC_EN
    logic [LB_FRAC_W-1:0] frac;
`endif
    logic          cs;
    logic          load;
    logic          tick;
    logic          mid_sample;
    logic          baud_done;
    logic [OW-1:0] ovs_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int ld; int en; int pre; int ov;
        int t;  int m;  int d;   int cnt;
    } vec_t;

    vec_t vt[$];

    lb_baud_tick_gen dut (
        .clk        (clk),
        .reset      (reset),
        .prescale   (prescale),
        .ovs        (ovs),
`ifdef LB_BAUD_FRAC_EN
        .frac       (frac),
`endif
        .cs         (cs),
        .load       (load),
        .tick       (tick),
        .mid_sample (mid_sample),
        .baud_done  (baud_done),
        .ovs_cnt    (ovs_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic l, input logic c);
        load = l;
        cs   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int ld, input int en, input int pre, input int ov,
                       input int t, input int m, input int d, input int cnt);
        vec_t v;
        v.ld = ld; v.en = en; v.pre = pre; v.ov = ov;
        v.t = t; v.m = m; v.d = d; v.cnt = cnt;
        vt.push_back(v);
    endtask

    initial begin
        // prescale=1, ovs=2: tick every 2 clk, mid on index 1, done on index 2
        add(1,0,1,2, 0,0,0,0);
        add(0,1,5,5, 0,0,0,0);
        add(0,1,5,5, 1,0,0,1);
        add(0,1,5,5, 0,0,0,1);
        add(0,1,5,5, 1,1,0,2);
        add(0,1,5,5, 0,0,0,2);
        add(0,1,5,5, 1,0,1,0);
        add(0,1,5,5, 0,0,0,0);
        add(0,1,5,5, 1,0,0,1);
        add(0,0,5,5, 0,0,0,1);
        add(0,0,5,5, 0,0,0,1);
        add(0,1,5,5, 0,0,0,1);
        add(0,1,5,5, 1,1,0,2);
        // prescale=0, ovs=0: every pulse every cycle; cs=0 gives all zero
        add(1,1,0,0, 0,0,0,0);
        add(0,1,5,5, 1,1,1,0);
        add(0,1,5,5, 1,1,1,0);
        add(0,1,5,5, 1,1,1,0);
        for (int i = 0; i < 5; i++) add(0,0,5,5, 0,0,0,0);
        add(0,1,5,5, 1,1,1,0);
        // load with cs=0, prescale=2, ovs=1
        add(1,0,2,1, 0,0,0,0);
        add(0,0,5,5, 0,0,0,0);
        add(0,1,5,5, 0,0,0,0);
        add(0,1,5,5, 0,0,0,0);
        add(0,1,5,5, 1,1,0,1);
        add(0,1,5,5, 0,0,0,1);
        add(0,1,5,5, 0,0,0,1);
        add(0,1,5,5, 1,0,1,0);

        reset = 1'b1; cs = 1'b0; load = 1'b0; prescale = '0; ovs = '0;
`ifdef LB_BAUD_FRAC_EN
        frac = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_mid", int'(mid_sample), 0);
        chk("rst_done", int'(baud_done), 0);
        chk("rst_cnt", int'(ovs_cnt), 0);

        // Run on defaults, then assert reset asynchronously while a tick is high
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        chk("pre_rst_tick", int'(tick), 1);
        chk("pre_rst_cnt", int'(ovs_cnt), 5);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_cnt", int'(ovs_cnt), 0);
        chk("async_rst_mid", int'(mid_sample), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b1);
            chk("def_tick", int'(tick), 1);
            chk("def_cnt", int'(ovs_cnt), i % 16);
            chk("def_done", int'(baud_done), int'(i % 16 == 0));
            chk("def_mid", int'(mid_sample), int'(i % 16 == 8));
        end

        // prescale=3, ovs=15
        prescale = PW'(3); ovs = OW'(15);
        step(1'b1, 1'b0);
        chk("p3_load_tick", int'(tick), 0);
        chk("p3_load_cnt", int'(ovs_cnt), 0);
        for (int i = 1; i <= 200; i++) begin
            step(1'b0, 1'b1);
            chk("p3_tick", int'(tick), int'(i % 4 == 0));
            chk("p3_cnt", int'(ovs_cnt), (i / 4) % 16);
            chk("p3_done", int'(baud_done), int'(i % 64 == 0));
            chk("p3_mid", int'(mid_sample), int'(i % 64 == 32));
        end

        foreach (vt[k]) begin
            prescale = PW'(vt[k].pre);
            ovs      = OW'(vt[k].ov);
            step(vt[k].ld[0], vt[k].en[0]);
            chk($sformatf("vec%0d_tick", k), int'(tick), vt[k].t);
            chk($sformatf("vec%0d_mid", k), int'(mid_sample), vt[k].m);
            chk($sformatf("vec%0d_done", k), int'(baud_done), vt[k].d);
            chk($sformatf("vec%0d_cnt", k), int'(ovs_cnt), vt[k].cnt);
        end

        // prescale=9, ovs=7; reload with prescale=1 on the edge of the third tick
        prescale = PW'(9); ovs = OW'(7);
        step(1'b1, 1'b0);
        for (int i = 1; i <= 29; i++) step(1'b0, 1'b1);
        chk("p9_cnt_before", int'(ovs_cnt), 2);
        prescale = PW'(1);
        step(1'b1, 1'b1);
        chk("reload_tick", int'(tick), 0);
        chk("reload_mid", int'(mid_sample), 0);
        chk("reload_done", int'(baud_done), 0);
        chk("reload_cnt", int'(ovs_cnt), 0);
        for (int j = 1; j <= 16; j++) begin
            step(1'b0, 1'b1);
            chk("rl_tick", int'(tick), int'(j % 2 == 0));
            chk("rl_cnt", int'(ovs_cnt), (j / 2) % 8);
            chk("rl_done", int'(baud_done), int'(j == 16));
            chk("rl_mid", int'(mid_sample), int'(j == 8));
        end

        // load together with cs=0, then hold cs=0 for 5 clk before counting
        prescale = PW'(4); ovs = OW'(3);
        step(1'b1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 1'b0);
            chk("idle_tick", int'(tick), 0);
            chk("idle_cnt", int'(ovs_cnt), 0);
        end
        for (int j = 1; j <= 10; j++) begin
            step(1'b0, 1'b1);
            chk("cs_tick", int'(tick), int'(j % 5 == 0));
            chk("cs_cnt", int'(ovs_cnt), j / 5);
        end

`ifdef LB_BAUD_FRAC_EN
        begin
            int nt;
            int last;
            int per[5];
            nt = 0; last = 0;
            for (int j = 0; j < 5; j++) per[j] = 0;
            prescale = PW'(9); ovs = OW'(15); frac = LB_FRAC_W'(128);
            step(1'b1, 1'b0);
            for (int n = 1; n <= 12000 && nt < 1000; n++) begin
                step(1'b0, 1'b1);
                if (tick) begin
                    if (nt < 5) per[nt] = n - last;
                    last = n;
                    nt++;
                end
            end
            chk("frac_ticks", nt, 1000);
            chk("frac_per0", per[0], 10);
            chk("frac_per1", per[1], 10);
            chk("frac_per2", per[2], 11);
            chk("frac_per3", per[3], 10);
            chk("frac_per4", per[4], 11);
            chk("frac_total_in_range", int'(last >= 10499 && last <= 10501), 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
